// File: rtl/uart_tx_port_if.sv
// CPU-side bus bundle for the memory-mapped serial transmitter page.
// The master drives select/strobe/data and the slave returns read data.
interface uart_tx_port_if;
  logic       cs;
  logic       addr;
  logic       wr_n;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output cs, output addr, output wr_n, output din, input dout);
  modport slave  (input cs, input addr, input wr_n, input din, output dout);
endinterface

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 serial transmitter: the CPU pushes bytes into a small FIFO.
// A bit-timed FSM shifts each byte out LSB first on an idle-high TX line.
module uart_tx_port #(
  parameter int CLK_HZ  = 24000000,
  parameter int BAUD    = 115200,
  parameter int FIFO_AW = 4
) (
  input  logic           clk_24,
  input  logic           reset_n,
  uart_tx_port_if.slave  bus,
  output logic           tx,
  output logic           busy
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH = 2 ** FIFO_AW;

  localparam logic [FIFO_AW:0]   CNT_ZERO = {(FIFO_AW + 1){1'b0}};
  localparam logic [FIFO_AW:0]   CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1'b1);
  localparam logic [CNT_W-1:0]   BAUD_TOP = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]   BAUD_ONE = CNT_W'(1'b1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [1:0]         rst_sync_r;
  logic               rst_n_s;
  logic               we_s;
  logic               we_q_r;
  logic               we_rise_s;
  logic               data_wr_s;
  logic               ctrl_wr_s;
  logic               flush_s;
  logic               ovf_clr_s;
  logic               push_s;
  logic               drop_s;
  logic               pop_s;
  logic               full_s;
  logic               ovf_r;
  logic [7:0]         mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [FIFO_AW:0]   count_r;
  state_t             state_r;
  state_t             state_nx;
  logic [CNT_W-1:0]   baud_cnt_r;
  logic [CNT_W-1:0]   baud_nx;
  logic               baud_wrap_s;
  logic [2:0]         bit_idx_r;
  logic [2:0]         bit_nx;
  logic [7:0]         shift_r;
  logic [7:0]         shift_nx;
  logic               tx_nx;
  logic               tx_r;
  logic               busy_r;
  logic [4:0]         count5_s;
  logic [7:0]         status_s;

  // Reset asserts immediately and releases two clocks later, synchronous to clk_24
  always_ff @(posedge clk_24 or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  // A held strobe must act only once, so only its rising edge counts
  assign we_s      = bus.cs & ~bus.wr_n;
  assign we_rise_s = we_s & ~we_q_r;
  assign data_wr_s = we_rise_s & ~bus.addr;
  assign ctrl_wr_s = we_rise_s & bus.addr;
  assign flush_s   = ctrl_wr_s & bus.din[0];
  assign ovf_clr_s = ctrl_wr_s & bus.din[1];
  assign full_s    = (count_r == CNT_FULL);
  // A simultaneous pop frees a slot, so a write to a full FIFO still lands
  assign push_s    = data_wr_s & (~full_s | pop_s);
  assign drop_s    = data_wr_s & full_s & ~pop_s;

  // Registered copy of the write strobe for edge detection
  always_ff @(posedge clk_24 or negedge rst_n_s) begin
    if (!rst_n_s) begin
      we_q_r <= 1'b0;
    end else begin
      we_q_r <= we_s;
    end
  end

  // FIFO storage, written only on an accepted push
  always_ff @(posedge clk_24) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.din;
    end
  end

  // FIFO pointers and occupancy; a flush discards everything not yet popped
  always_ff @(posedge clk_24 or negedge rst_n_s) begin
    if (!rst_n_s) begin
      wr_ptr_r <= {FIFO_AW{1'b0}};
      rd_ptr_r <= {FIFO_AW{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (flush_s) begin
        rd_ptr_r <= wr_ptr_r;
        count_r  <= CNT_ZERO;
      end else begin
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CNT_ONE;
          2'b01:   count_r <= count_r - CNT_ONE;
          default: count_r <= count_r;
        endcase
      end
    end
  end

  // Sticky overflow flag, cleared only by a CTRL write
  always_ff @(posedge clk_24 or negedge rst_n_s) begin
    if (!rst_n_s) begin
      ovf_r <= 1'b0;
    end else if (ovf_clr_s) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end
  end

  assign baud_wrap_s = (baud_cnt_r == BAUD_TOP);

  // Frame sequencer next-state, pop request and serial bit selection
  always_comb begin
    state_nx = state_r;
    baud_nx  = baud_cnt_r;
    bit_nx   = bit_idx_r;
    shift_nx = shift_r;
    pop_s    = 1'b0;
    tx_nx    = 1'b1;
    case (state_r)
      IDLE: begin
        tx_nx = 1'b1;
        if (count_r != CNT_ZERO) begin
          pop_s    = 1'b1;
          shift_nx = mem_r[rd_ptr_r];
          baud_nx  = {CNT_W{1'b0}};
          bit_nx   = 3'd0;
          state_nx = START;
        end else begin
          state_nx = IDLE;
        end
      end
      START: begin
        tx_nx = 1'b0;
        if (baud_wrap_s) begin
          baud_nx  = {CNT_W{1'b0}};
          state_nx = DATA;
        end else begin
          baud_nx = baud_cnt_r + BAUD_ONE;
        end
      end
      DATA: begin
        tx_nx = shift_r[0];
        if (baud_wrap_s) begin
          baud_nx  = {CNT_W{1'b0}};
          shift_nx = {1'b0, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            state_nx = STOP;
          end else begin
            bit_nx = bit_idx_r + 3'd1;
          end
        end else begin
          baud_nx = baud_cnt_r + BAUD_ONE;
        end
      end
      STOP: begin
        tx_nx = 1'b1;
        if (baud_wrap_s) begin
          baud_nx  = {CNT_W{1'b0}};
          state_nx = IDLE;
        end else begin
          baud_nx = baud_cnt_r + BAUD_ONE;
        end
      end
      default: begin
        tx_nx    = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  // Frame sequencer state and datapath registers
  always_ff @(posedge clk_24 or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r    <= IDLE;
      baud_cnt_r <= {CNT_W{1'b0}};
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
    end else begin
      state_r    <= state_nx;
      baud_cnt_r <= baud_nx;
      bit_idx_r  <= bit_nx;
      shift_r    <= shift_nx;
    end
  end

  // Registered line and busy outputs; reset forces the line idle at once
  always_ff @(posedge clk_24 or negedge rst_n_s) begin
    if (!rst_n_s) begin
      tx_r   <= 1'b1;
      busy_r <= 1'b0;
    end else begin
      tx_r   <= tx_nx;
      busy_r <= (state_r != IDLE) | (count_r != CNT_ZERO);
    end
  end

  assign tx       = tx_r;
  assign busy     = busy_r;
  assign count5_s = 5'(count_r);
  assign status_s = {full_s, ovf_r, busy_r, count5_s};
  assign bus.dout = bus.addr ? status_s : 8'h00;

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port at DIV=10; a bench-side UART receiver
// decodes the line independently by mid-bit sampling.
module tb_uart_tx_port;

  logic clk_24;
  logic reset_n;
  logic tx;
  logic busy;
  int   checks;
  int   failures;

  uart_tx_port_if bus_if ();

  uart_tx_port #(.CLK_HZ(1000), .BAUD(100), .FIFO_AW(4)) dut (
    .clk_24  (clk_24),
    .reset_n (reset_n),
    .bus     (bus_if.slave),
    .tx      (tx),
    .busy    (busy)
  );

  initial clk_24 = 1'b0;
  always #5 clk_24 = ~clk_24;

  // Bench receiver: start bit detected on first low sample, bits read at mid-period
  logic [7:0] rx_q [$];
  logic [7:0] mon_byte;
  logic       mon_active;
  int         mon_cnt;
  int         mon_err;

  initial begin
    mon_active = 1'b0;
    mon_cnt    = 0;
    mon_err    = 0;
    mon_byte   = 8'h00;
  end

  always @(negedge clk_24) begin
    if (!reset_n) begin
      mon_active <= 1'b0;
      mon_cnt    <= 0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active <= 1'b1;
        mon_cnt    <= 1;
      end
    end else begin
      mon_cnt <= mon_cnt + 1;
      if (mon_cnt == 5 && tx !== 1'b0) begin
        mon_err    <= mon_err + 1;
        mon_active <= 1'b0;
      end else if (mon_cnt >= 15 && mon_cnt <= 85 && ((mon_cnt - 5) % 10) == 0) begin
        mon_byte[(mon_cnt - 15) / 10] <= tx;
      end else if (mon_cnt == 95) begin
        if (tx !== 1'b1) mon_err <= mon_err + 1;
        rx_q.push_back(mon_byte);
        mon_active <= 1'b0;
      end
    end
  end

  task automatic cpu_write(input logic a, input logic [7:0] d, input int hold);
    @(negedge clk_24);
    bus_if.addr = a;
    bus_if.din  = d;
    bus_if.cs   = 1'b1;
    bus_if.wr_n = 1'b0;
    repeat (hold) @(negedge clk_24);
    bus_if.cs   = 1'b0;
    bus_if.wr_n = 1'b1;
  endtask

  task automatic read_reg(input logic a, output logic [7:0] d);
    bus_if.addr = a;
    #1;
    d = bus_if.dout;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int t;
    t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(negedge clk_24);
      t++;
    end
  endtask

  task automatic test_reset;
    int bad;
    logic [7:0] st;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_24);
      read_reg(1'b1, st);
      if (tx !== 1'b1 || busy !== 1'b0 || st !== 8'h00) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reset_idle: %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic test_frame_a5;
    logic [7:0] v;
    logic [7:0] st;
    logic exp_tx;
    int bad;
    int first_bad;
    v = 8'hA5;
    bad = 0;
    first_bad = -1;
    rx_q.delete();
    cpu_write(1'b0, v, 1);
    for (int k = 0; k <= 105; k++) begin
      if (k > 0) @(negedge clk_24);
      if (k < 2) exp_tx = 1'b1;
      else if (k < 12) exp_tx = 1'b0;
      else if (k < 92) exp_tx = v[(k - 12) / 10];
      else exp_tx = 1'b1;
      if (tx !== exp_tx) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
      if (k == 50) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_mid_frame: got %b required 1", busy);
        end
      end
      if (k == 102) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL busy_after_frame: got %b required 0", busy);
        end
      end
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL frame_a5_timing: %0d bad cycles, first at N+%0d, required 0", bad, first_bad);
    end
    read_reg(1'b1, st);
    checks++;
    if (st !== 8'h00) begin
      failures++;
      $display("FAIL status_after_a5: got %h required 00", st);
    end
  endtask

  task automatic test_held_strobe;
    rx_q.delete();
    cpu_write(1'b0, 8'h41, 5);
    repeat (250) @(negedge clk_24);
    checks++;
    if (rx_q.size() !== 1) begin
      failures++;
      $display("FAIL held_strobe_count: got %0d frames required 1", rx_q.size());
    end else begin
      checks++;
      if (rx_q[0] !== 8'h41) begin
        failures++;
        $display("FAIL held_strobe_data: got %h required 41", rx_q[0]);
      end
    end
  endtask

  task automatic test_overflow;
    logic [7:0] st;
    logic [7:0] exp_b;
    int bad;
    rx_q.delete();
    for (int i = 0; i < 18; i++) begin
      exp_b = 8'h10 + 8'(i);
      cpu_write(1'b0, exp_b, 1);
    end
    read_reg(1'b1, st);
    checks++;
    if (st !== 8'hF0) begin
      failures++;
      $display("FAIL status_full_ovf: got %h required F0", st);
    end
    read_reg(1'b0, st);
    checks++;
    if (st !== 8'h00) begin
      failures++;
      $display("FAIL data_read_zero: got %h required 00", st);
    end
    wait_rx(17, 2500);
    repeat (20) @(negedge clk_24);
    checks++;
    if (rx_q.size() !== 17) begin
      failures++;
      $display("FAIL ovf_frame_count: got %0d required 17", rx_q.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 17; i++) begin
        exp_b = 8'h10 + 8'(i);
        if (rx_q[i] !== exp_b) bad++;
      end
      checks++;
      if (bad !== 0) begin
        failures++;
        $display("FAIL ovf_frame_order: %0d wrong bytes required 0", bad);
      end
    end
    read_reg(1'b1, st);
    checks++;
    if (st !== 8'h40) begin
      failures++;
      $display("FAIL status_drained_ovf: got %h required 40", st);
    end
    cpu_write(1'b1, 8'h02, 1);
    @(negedge clk_24);
    read_reg(1'b1, st);
    checks++;
    if (st !== 8'h00) begin
      failures++;
      $display("FAIL status_ovf_cleared: got %h required 00", st);
    end
  endtask

  task automatic test_flush;
    logic [7:0] st;
    rx_q.delete();
    cpu_write(1'b0, 8'h11, 1);
    cpu_write(1'b0, 8'h22, 1);
    cpu_write(1'b0, 8'h33, 1);
    repeat (24) @(negedge clk_24);
    cpu_write(1'b1, 8'h01, 1);
    @(negedge clk_24);
    read_reg(1'b1, st);
    checks++;
    if (st !== 8'h20) begin
      failures++;
      $display("FAIL status_after_flush: got %h required 20", st);
    end
    repeat (200) @(negedge clk_24);
    checks++;
    if (rx_q.size() !== 1) begin
      failures++;
      $display("FAIL flush_frame_count: got %0d required 1", rx_q.size());
    end else begin
      checks++;
      if (rx_q[0] !== 8'h11) begin
        failures++;
        $display("FAIL flush_frame_data: got %h required 11", rx_q[0]);
      end
    end
    read_reg(1'b1, st);
    checks++;
    if (st !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle: status %h busy %b required 00 0", st, busy);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] st;
    int lows;
    rx_q.delete();
    cpu_write(1'b0, 8'h5A, 1);
    repeat (13) @(negedge clk_24);
    checks++;
    if (tx !== 1'b0) begin
      failures++;
      $display("FAIL pre_reset_bit0: got %b required 0", tx);
    end
    reset_n = 1'b0;
    #1;
    read_reg(1'b1, st);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || st !== 8'h00) begin
      failures++;
      $display("FAIL async_reset: tx %b busy %b status %h required 1 0 00", tx, busy, st);
    end
    repeat (3) @(negedge clk_24);
    rx_q.delete();
    reset_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_24);
      if (tx !== 1'b1) lows++;
    end
    read_reg(1'b1, st);
    checks++;
    if (lows !== 0 || rx_q.size() !== 0 || st !== 8'h00) begin
      failures++;
      $display("FAIL no_resume: low cycles %0d frames %0d status %h required 0 0 00", lows, rx_q.size(), st);
    end
    cpu_write(1'b0, 8'hC3, 1);
    wait_rx(1, 300);
    checks++;
    if (rx_q.size() !== 1) begin
      failures++;
      $display("FAIL post_reset_count: got %0d required 1", rx_q.size());
    end else begin
      checks++;
      if (rx_q[0] !== 8'hC3) begin
        failures++;
        $display("FAIL post_reset_data: got %h required C3", rx_q[0]);
      end
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset_n     = 1'b0;
    bus_if.cs   = 1'b0;
    bus_if.addr = 1'b0;
    bus_if.wr_n = 1'b1;
    bus_if.din  = 8'h00;
    repeat (4) @(negedge clk_24);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_24);
    test_reset();
    test_frame_a5();
    test_held_strobe();
    test_overflow();
    test_flush();
    test_reset_mid_frame();
    checks++;
    if (mon_err !== 0) begin
      failures++;
      $display("FAIL receiver_framing: got %0d errors required 0", mon_err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
